conv_seq_ctrl: RTL
==================

# conv_seq_ctrl

Sequencer for the convolution datapath of the ID1000500A IP-core. It takes a start pulse and the configuration word from the AIP interface. It walks every (x, y) index pair of the full linear convolution Z[k] = Σ X[j]·Y[k−j], drives the read addresses of memory-in 0/1, and issues load/accumulate strobes to a separate MAC register. It also writes each finished Z[k] to memory-out 0 and reports busy/done/config-error back to the AIP status/interrupt bits.

## Interface
Parameters:
- ADDR_WIDTH, 5, address width of memory-in 0/1; max vector length 2^ADDR_WIDTH.
- Derived, not overridable: size fields and Z address are ADDR_WIDTH+1 bits wide.

Ports:
- clk  in  1  single clock, rising edge.
- rst_a  in  1  reset, asynchronous, active-high.
- start  in  1  start request, sampled on clk.
- config_in  in  32  [5:0] = size_x, [11:6] = size_y; other bits ignored.
- mem_x_addr  out  ADDR_WIDTH  read address, memory-in 0 (X).
- mem_y_addr  out  ADDR_WIDTH  read address, memory-in 1 (Y).
- mac_en  out  1  MAC update this cycle.
- mac_load  out  1  with mac_en: acc ← product (first term of a Z[k]); else acc ← acc + product.
- mem_z_addr  out  ADDR_WIDTH+1  write address, memory-out 0.
- mem_z_we  out  1  write enable; data = MAC accumulator register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse (interrupt source).
- cfg_err  out  1  last accepted start had an invalid size.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → latch size_x and size_y.
  - Size valid iff 1 ≤ size ≤ 2^ADDR_WIDTH, for both fields.
  - Valid → RUN, cfg_err←0.
  - Invalid → DONE, cfg_err←1; no memory reads, MAC strobes or Z writes.
- RUN: one term issued per cycle. Order:
  - k from 0 to N−1, with N = size_x + size_y − 1.
  - Within each k, j ascends from max(0, k−size_y+1) to min(k, size_x−1).
  - mem_x_addr = j, mem_y_addr = k−j.
  - After the last term of k = N−1 → DRAIN.
- DRAIN: 2 cycles, flushing the pipeline, then → DONE.
- DONE: 1 cycle, done=1, then → IDLE.
- Pipeline (memories have 1-cycle synchronous read):
  - Term issued in cycle t → mac_en=1 in t+1.
  - mac_load=1 in t+1 iff the term is the first j of its k.
  - Last term of k issued in t → mem_z_we=1 and mem_z_addr=k in t+2.
  - Fully pipelined: no bubbles between k groups. The next k's load in t+2 coincides with the Z[k] write, which captures the pre-edge accumulator.
- start while not IDLE: ignored. Config changes after acceptance: ignored.
- Counter arithmetic:
  - k and j counters are ADDR_WIDTH+1 bits. Bound computations use ADDR_WIDTH+2 bits, so no wrap at size_x = size_y = 32 (N = 63, k−j ≤ 31).
  - Address outputs are the low ADDR_WIDTH bits.
- Reset values: all outputs 0, state IDLE, latched sizes 0.
- rst_a mid-operation: immediate abort. Outputs return to 0 asynchronously, and there is no done pulse. A pending Z write is lost.

## Timing
- Cycle 0: start sampled high.
- Cycles 1 … S, with S = size_x·size_y: term issue (RUN).
- busy=1 in cycles 1 … S+2; mem_z_we last asserted in cycle S+2.
- done=1 in cycle S+3, busy=0. Start-to-done latency: S+3 cycles.
- The next start is accepted in cycle S+4 or later. A start in cycle S+3 (DONE) is ignored.
- Invalid config: busy never rises. done=1 in cycle 1, cfg_err=1 from cycle 1 until the next accepted start.
- Outside RUN: mem_x_addr and mem_y_addr hold 0; mac_en, mac_load and mem_z_we are 0.
- Exactly N Z writes per valid run, at addresses 0 … N−1 in ascending order.

## Test plan
- size_x=1, size_y=1 → one issue (0,0) in cycle 1; mac_en+mac_load in cycle 2; mem_z_we at addr 0 in cycle 3; done in cycle 4. With X[0]=3, Y[0]=5, Z[0]=15.
- size_x=3, size_y=2 → issue pairs (0,0), (0,1), (1,0), (1,1), (2,0), (2,1) in cycles 1–6:
  - mac_load in cycles 2, 3, 5, 7.
  - Z writes addr 0, 1, 2, 3 in cycles 3, 5, 7, 8; done in cycle 9.
  - X = {1,2,3}, Y = {4,5} → Z = {4,13,22,15}.
- size_x=32, size_y=32 → 1024 issues, 63 writes to addr 0–62, no address wrap, done in cycle 1027.
  - All-ones data: Z[k] = min(k+1, 63−k).
- size_x=0 or size_y=33 → done in cycle 1, cfg_err=1, zero reads/writes. A following valid start clears cfg_err in its cycle 1.
- start re-asserted during RUN and during DONE → ignored; the sequence and done timing are unchanged.
- rst_a asserted in cycle 4 of the 3×2 run → all outputs 0 immediately, no done. A new start after release runs a complete, correct sequence.

Source files
------------

// File: rtl/conv_seq_ctrl_if.sv
// AIP-side control/status and datapath strobes of the convolution sequencer.
// The sequencer takes the master modport; the AIP/datapath side takes the slave modport.
interface conv_seq_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                  start;
    logic [31:0]           config_in;
    logic [ADDR_WIDTH-1:0] mem_x_addr;
    logic [ADDR_WIDTH-1:0] mem_y_addr;
    logic                  mac_en;
    logic                  mac_load;
    logic [ADDR_WIDTH:0]   mem_z_addr;
    logic                  mem_z_we;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    modport master (
        input  start, config_in,
        output mem_x_addr, mem_y_addr, mac_en, mac_load, mem_z_addr, mem_z_we,
        output busy, done, cfg_err
    );

    modport slave (
        output start, config_in,
        input  mem_x_addr, mem_y_addr, mac_en, mac_load, mem_z_addr, mem_z_we,
        input  busy, done, cfg_err
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a full linear convolution: walks every (j, k-j) pair in k-major order,
// strobes an external MAC one cycle after each read and writes Z[k] two cycles after its last term.
module conv_seq_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic             clk,
    input logic             rst_a,
    conv_seq_ctrl_if.master bus
);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned BW = ADDR_WIDTH + 2;
    localparam logic [BW-1:0] MAX_LEN = BW'(2 ** ADDR_WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] size_x_q, size_x_d, size_y_q, size_y_d;
    logic [CW-1:0] k_q, k_d, j_q, j_d;
    logic          cfg_err_q, cfg_err_d;
    logic          drain_q, drain_d;

    logic          mac_en_q, mac_load_q;
    logic          z_pend_q;
    logic [CW-1:0] z_k_q;
    logic          z_we_q;
    logic [CW-1:0] z_addr_q;

    logic [CW-1:0] cfg_x, cfg_y;
    logic          cfg_ok;
    logic [BW-1:0] k_ext, j_ext, sx_ext, sy_ext;
    logic [BW-1:0] j_lo, j_hi, k_nxt, j_lo_nxt, n_m1;
    logic          issue, term_first, term_last, run_end;
    logic [CW-1:0] y_diff;
    logic          unused_bits;

    assign cfg_x  = bus.config_in[CW-1:0];
    assign cfg_y  = bus.config_in[2*CW-1:CW];
    assign cfg_ok = (cfg_x != '0) && (cfg_y != '0) &&
                    ({1'b0, cfg_x} <= MAX_LEN) && ({1'b0, cfg_y} <= MAX_LEN);

    // Bounds are one bit wider than the counters so 32x32 (N = 63) never wraps.
    assign k_ext    = {1'b0, k_q};
    assign j_ext    = {1'b0, j_q};
    assign sx_ext   = {1'b0, size_x_q};
    assign sy_ext   = {1'b0, size_y_q};
    assign j_lo     = (k_ext >= sy_ext) ? k_ext - sy_ext + BW'(1) : '0;
    assign j_hi     = (k_ext < sx_ext - BW'(1)) ? k_ext : sx_ext - BW'(1);
    assign k_nxt    = k_ext + BW'(1);
    assign j_lo_nxt = (k_nxt >= sy_ext) ? k_nxt - sy_ext + BW'(1) : '0;
    assign n_m1     = sx_ext + sy_ext - BW'(2);

    assign issue      = (state_q == StRun);
    assign term_first = (j_ext == j_lo);
    assign term_last  = (j_ext == j_hi);
    assign run_end    = term_last && (k_ext == n_m1);

    always_comb begin
        state_d   = state_q;
        size_x_d  = size_x_q;
        size_y_d  = size_y_q;
        k_d       = k_q;
        j_d       = j_q;
        cfg_err_d = cfg_err_q;
        drain_d   = drain_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    size_x_d = cfg_x;
                    size_y_d = cfg_y;
                    k_d      = '0;
                    j_d      = '0;
                    if (cfg_ok) begin
                        state_d   = StRun;
                        cfg_err_d = 1'b0;
                    end else begin
                        state_d   = StDone;
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (term_last) begin
                    if (run_end) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                        k_d     = '0;
                        j_d     = '0;
                    end else begin
                        k_d = k_nxt[CW-1:0];
                        j_d = j_lo_nxt[CW-1:0];
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            StDrain: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q    <= StIdle;
            size_x_q   <= '0;
            size_y_q   <= '0;
            k_q        <= '0;
            j_q        <= '0;
            cfg_err_q  <= 1'b0;
            drain_q    <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_load_q <= 1'b0;
            z_pend_q   <= 1'b0;
            z_k_q      <= '0;
            z_we_q     <= 1'b0;
            z_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            size_x_q   <= size_x_d;
            size_y_q   <= size_y_d;
            k_q        <= k_d;
            j_q        <= j_d;
            cfg_err_q  <= cfg_err_d;
            drain_q    <= drain_d;
            // Memory read takes one cycle, so MAC strobes trail the issued term by one cycle.
            mac_en_q   <= issue;
            mac_load_q <= issue && term_first;
            z_pend_q   <= issue && term_last;
            z_k_q      <= k_q;
            z_we_q     <= z_pend_q;
            z_addr_q   <= z_pend_q ? z_k_q : '0;
        end
    end

    assign y_diff = k_q - j_q;

    assign bus.mem_x_addr = issue ? j_q[ADDR_WIDTH-1:0] : '0;
    assign bus.mem_y_addr = issue ? y_diff[ADDR_WIDTH-1:0] : '0;
    assign bus.mac_en     = mac_en_q;
    assign bus.mac_load   = mac_load_q;
    assign bus.mem_z_we   = z_we_q;
    assign bus.mem_z_addr = z_addr_q;
    assign bus.busy       = (state_q == StRun) || (state_q == StDrain);
    assign bus.done       = (state_q == StDone);
    assign bus.cfg_err    = cfg_err_q;

    assign unused_bits = ^{bus.config_in[31:2*CW], y_diff[CW-1], k_nxt[BW-1], j_lo_nxt[BW-1]};
endmodule
